// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads one word per PC value, holds it for the decode
// stage, and tells the upstream PC to advance or jump when the word is accepted.
module fetch_stage #(
  parameter int ADDR_W  = 12,
  parameter int WORD_W  = 15,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_enable,
  output logic              jump_select,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [2:0]        instr_opcode,
  output logic [ADDR_W-1:0] instr_operand,
  output logic              fetch_err,
  output logic [15:0]       retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  localparam logic [2:0] OP_TC     = 3'b000;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [ADDR_W-1:0] operand_q, operand_d;
  logic [15:0]       retired_q, retired_d;
  logic              transfer;

  // Handshake: a word moves to decode in exactly the cycles where instr_valid and
  // instr_ready are both high; instr_valid never drops before that, and
  // instr_ready on its own has no effect.
  assign transfer = (state_q == S_HOLD) && instr_ready;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = 4'd0;
      end
      S_FETCH: begin
        if (mem_ack) begin
          opcode_d  = mem_rdata[14:12];
          operand_d = mem_rdata[11:0];
          state_d   = S_HOLD;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (transfer) begin
          state_d   = S_FETCH;
          wait_d    = 4'd0;
          retired_d = retired_q + 16'd1;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      opcode_q  <= 3'd0;
      operand_q <= '0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      retired_q <= retired_d;
    end
  end

  // PC is held during FETCH, so the address can pass straight through.
  assign mem_req       = (state_q == S_FETCH);
  assign mem_addr      = mem_req ? pc_addr : '0;
  assign instr_valid   = (state_q == S_HOLD);
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign pc_enable     = transfer;
  assign jump_select   = transfer && (opcode_q == OP_TC);
  assign jump_addr     = jump_select ? operand_q : '0;
  assign fetch_err     = (state_q == S_ERROR);
  assign retired       = retired_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of instructions with memory/decode latencies,
// plus hand-built sequences for timeout, asynchronous reset and counter wrap.
module tb_fetch_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pc_addr = '0;
  logic        pc_enable, jump_select, mem_req, instr_valid, fetch_err;
  logic [11:0] jump_addr, mem_addr, instr_operand;
  logic        mem_ack = 1'b0;
  logic [14:0] mem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic [2:0]  instr_opcode;
  logic [15:0] retired;

  fetch_stage #(.ADDR_W(12), .WORD_W(15), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_enable(pc_enable),
    .jump_select(jump_select), .jump_addr(jump_addr), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .fetch_err(fetch_err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] operand;
    int          ack_wait;
    int          ready_wait;
    logic        exp_jump;
    logic [11:0] exp_jaddr;
  } vec_t;

  vec_t        vecs[8];
  logic [14:0] exp_q[$];
  logic [15:0] exp_retired;
  logic [11:0] pc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_valid"}, 32'(instr_valid), 0);
    check({tag, "_pc_en"}, 32'(pc_enable), 0);
    check({tag, "_jsel"}, 32'(jump_select), 0);
    check({tag, "_jaddr"}, 32'(jump_addr), 0);
    check({tag, "_opcode"}, 32'(instr_opcode), 0);
    check({tag, "_operand"}, 32'(instr_operand), 0);
    check({tag, "_err"}, 32'(fetch_err), 0);
    check({tag, "_retired"}, 32'(retired), 0);
  endtask

  // Leaves the DUT in its first FETCH cycle, sampled just after a falling edge.
  task automatic apply_reset;
    rst_n = 1'b0;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
    mem_rdata = '0;
    pc = '0;
    pc_addr = '0;
    exp_q.delete();
    exp_retired = '0;
    @(negedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_mem_req", 32'(mem_req), 0);
    step;
  endtask

  task automatic run_instr(input vec_t v, input string tag);
    logic [14:0] exp_word;
    pc_addr = pc;
    for (int i = 0; i < v.ack_wait; i++) begin
      mem_ack = 1'b0;
      instr_ready = 1'($urandom_range(0, 1));
      #1;
      check({tag, "_wait_req"}, 32'(mem_req), 1);
      check({tag, "_wait_addr"}, 32'(mem_addr), 32'(pc));
      check({tag, "_wait_pc_en"}, 32'(pc_enable), 0);
      step;
    end
    mem_ack = 1'b1;
    mem_rdata = {v.op, v.operand};
    instr_ready = 1'($urandom_range(0, 1));
    exp_q.push_back({v.op, v.operand});
    #1;
    check({tag, "_ack_req"}, 32'(mem_req), 1);
    check({tag, "_ack_pc_en"}, 32'(pc_enable), 0);
    step;
    for (int i = 0; i < v.ready_wait; i++) begin
      instr_ready = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 15'($urandom);
      #1;
      check({tag, "_bp_valid"}, 32'(instr_valid), 1);
      check({tag, "_bp_req"}, 32'(mem_req), 0);
      check({tag, "_bp_pc_en"}, 32'(pc_enable), 0);
      check({tag, "_bp_jsel"}, 32'(jump_select), 0);
      check({tag, "_bp_opcode"}, 32'(instr_opcode), 32'(exp_q[0][14:12]));
      check({tag, "_bp_operand"}, 32'(instr_operand), 32'(exp_q[0][11:0]));
      step;
    end
    mem_ack = 1'b0;
    mem_rdata = 15'($urandom);
    instr_ready = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_queue: got empty expected queue required one entry", tag);
    end else begin
      exp_word = exp_q.pop_front();
      check({tag, "_xfer_valid"}, 32'(instr_valid), 1);
      check({tag, "_xfer_pc_en"}, 32'(pc_enable), 1);
      check({tag, "_xfer_jsel"}, 32'(jump_select), 32'(v.exp_jump));
      check({tag, "_xfer_jaddr"}, 32'(jump_addr), 32'(v.exp_jaddr));
      check({tag, "_xfer_opcode"}, 32'(instr_opcode), 32'(exp_word[14:12]));
      check({tag, "_xfer_operand"}, 32'(instr_operand), 32'(exp_word[11:0]));
    end
    exp_retired = exp_retired + 16'd1;
    step;
    instr_ready = 1'b0;
    pc = v.exp_jump ? v.exp_jaddr : pc + 12'd1;
    pc_addr = pc;
    #1;
    check({tag, "_retired"}, 32'(retired), 32'(exp_retired));
    check({tag, "_next_req"}, 32'(mem_req), 1);
    check({tag, "_next_addr"}, 32'(mem_addr), 32'(pc));
    check({tag, "_next_pc_en"}, 32'(pc_enable), 0);
  endtask

  initial begin
    vecs[0] = '{3'd3, 12'h005, 0, 0, 1'b0, 12'h000};
    vecs[1] = '{3'd5, 12'h0A7, 2, 5, 1'b0, 12'h000};
    vecs[2] = '{3'd0, 12'h123, 0, 0, 1'b1, 12'h123};
    vecs[3] = '{3'd7, 12'hFFF, TIMEOUT - 1, 1, 1'b0, 12'h000};
    vecs[4] = '{3'd0, 12'h000, 3, 2, 1'b1, 12'h000};
    vecs[5] = '{3'd1, 12'h800, 1, 0, 1'b0, 12'h000};
    vecs[6] = '{3'd0, 12'hABC, 0, 3, 1'b1, 12'hABC};
    vecs[7] = '{3'd4, 12'h555, 5, 0, 1'b0, 12'h000};

    apply_reset;
    for (int i = 0; i < 8; i++) run_instr(vecs[i], $sformatf("vec%0d", i));

    // Memory never answers: error after TIMEOUT fetch cycles, sticky until reset.
    apply_reset;
    for (int i = 0; i < TIMEOUT; i++) begin
      mem_ack = 1'b0;
      instr_ready = 1'b1;
      #1;
      check("to_wait_req", 32'(mem_req), 1);
      check("to_wait_err", 32'(fetch_err), 0);
      step;
    end
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      mem_rdata = 15'($urandom);
      instr_ready = 1'b1;
      #1;
      check("to_err", 32'(fetch_err), 1);
      check("to_req", 32'(mem_req), 0);
      check("to_valid", 32'(instr_valid), 0);
      check("to_pc_en", 32'(pc_enable), 0);
      step;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("to_rst_err", 32'(fetch_err), 0);

    // Reset between edges while fetching.
    apply_reset;
    run_instr(vecs[0], "pre_a");
    run_instr(vecs[5], "pre_b");
    mem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fetch_req", 32'(mem_req), 0);
    check("arst_fetch_retired", 32'(retired), 0);
    check("arst_fetch_addr", 32'(mem_addr), 0);

    // Reset between edges while holding a word.
    apply_reset;
    mem_ack = 1'b1;
    mem_rdata = {3'd6, 12'h3C3};
    step;
    mem_ack = 1'b0;
    #1;
    check("arst_hold_pre_valid", 32'(instr_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hold_valid", 32'(instr_valid), 0);
    check("arst_hold_opcode", 32'(instr_opcode), 0);
    check("arst_hold_operand", 32'(instr_operand), 0);

    // Counter wrap: preload 0xFFFF, then one more accepted instruction.
    apply_reset;
    force dut.retired_q = 16'hFFFF;
    #1;
    check("wrap_preload", 32'(retired), 32'hFFFF);
    release dut.retired_q;
    exp_retired = 16'hFFFF;
    run_instr(vecs[2], "wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 12, instruction address width (matches PC width)
  WORD_W, 15, memory word width; opcode = word[14:12], operand = word[11:0]
  TIMEOUT, 15, maximum FETCH cycles without mem_ack before error
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  pc_addr  in  12  current program counter from upstream PC
  pc_enable  out  1  one-cycle pulse: advance PC (or load jump_addr)
  jump_select  out  1  with pc_enable: PC loads jump_addr instead of +1
  jump_addr  out  12  jump target (valid when jump_select=1)
  mem_req  out  1  instruction memory read request
  mem_addr  out  12  read address
  mem_ack  in  1  read data valid this cycle
  mem_rdata  in  15  read data
  instr_valid  out  1  decoded instruction available to decode stage
  instr_ready  in  1  decode stage accepts instruction
  instr_opcode  out  3  registered word[14:12]
  instr_operand  out  12  registered word[11:0]
  fetch_err  out  1  sticky memory-timeout error
  retired  out  16  count of accepted instructions

Function
REQ-003 FSM states SHALL be IDLE, FETCH, HOLD, ERROR; reset state IDLE.
REQ-004 IDLE SHALL go to FETCH unconditionally on the next clock edge.
REQ-005 In FETCH: mem_req=1, mem_addr=pc_addr (combinational; PC is stable because pc_enable=0).
REQ-006 FETCH with mem_ack=1 SHALL capture mem_rdata into opcode/operand registers and go to HOLD; zero-wait ack in the first FETCH cycle is legal.
REQ-007 A 4-bit wait counter SHALL clear on FETCH entry, increment each FETCH cycle without mem_ack; reaching TIMEOUT without ack -> ERROR next edge.
REQ-008 In HOLD: instr_valid=1, mem_req=0; opcode/operand SHALL stay stable until accepted.
REQ-009 Handshake: transfer occurs in a cycle with instr_valid=1 and instr_ready=1; instr_ready while not valid SHALL be ignored.
REQ-010 On transfer: pc_enable=1 for exactly that cycle (combinational), retired increments, FSM goes to FETCH.
REQ-011 On transfer with opcode 3'b000 (TC): jump_select=1, jump_addr=operand in the same cycle; otherwise jump_select=0 and jump_addr=0.
REQ-012 pc_enable and jump_select SHALL be 0 in every non-transfer cycle.
REQ-013 retired SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-014 ERROR: fetch_err=1, mem_req=0, instr_valid=0, pc_enable=0; leaves only via reset.
REQ-015 mem_ack outside FETCH SHALL be ignored; mem_rdata is not sampled.

Reset
REQ-016 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and zero all outputs and registers (opcode, operand, retired, wait counter, fetch_err).
REQ-017 Reset asserted mid-FETCH or mid-HOLD SHALL drop mem_req/instr_valid in the same cycle; the pending instruction is discarded.

Verification
REQ-018 Reset release, pc_addr=0x000, mem_ack=1 on first FETCH cycle, rdata={011,0x005} -> instr_valid next cycle, opcode=3, operand=0x005; with instr_ready=1 -> pc_enable one cycle, jump_select=0, retired=1.
REQ-019 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr_valid=1, outputs stable, pc_enable=0, mem_req=0 throughout.
REQ-020 TC: rdata={000,0x123} accepted -> pc_enable=1, jump_select=1, jump_addr=0x123 in the same cycle; next cycle mem_req=1.
REQ-021 Timeout: mem_ack held 0 -> after TIMEOUT FETCH cycles fetch_err=1, mem_req=0; remains until rst_n=0.
REQ-022 Async reset: rst_n=0 between clock edges during FETCH -> mem_req=0 and retired=0 before next edge.
REQ-023 Wrap: force 65535 accepted instructions plus one -> retired=0x0000.
